// File: rtl/mac_accum_stage_if.sv
// mac_accum_stage_if: operand-issue and result handshake bundle for mac_accum_stage
//   master: beat issuer / product source / result consumer
//   slave : the accumulation stage
//   i_in_vld/o_in_rdy        operand beat handshake (beat also goes to mult32x32)
//   i_multa_ns/i_multb_ns    operand signedness as seen by the multiplier
//   i_in_last                beat closes the current sequence
//   i_product                mult32x32 product, MULT_LAT cycles after its beat
//   o_res/o_res_ovf          result FIFO head: sequence sum and overflow flag
//   o_res_vld/i_res_rdy      result handshake
//   o_busy                   work in flight, partial sum pending or results queued
interface mac_accum_stage_if #(parameter int ACC_W = 72);
  logic             i_in_vld;
  logic             o_in_rdy;
  logic             i_multa_ns;
  logic             i_multb_ns;
  logic             i_in_last;
  logic [63:0]      i_product;
  logic [ACC_W-1:0] o_res;
  logic             o_res_ovf;
  logic             o_res_vld;
  logic             i_res_rdy;
  logic             o_busy;
  modport master (
    output i_in_vld, i_multa_ns, i_multb_ns, i_in_last, i_product, i_res_rdy,
    input  o_in_rdy, o_res, o_res_ovf, o_res_vld, o_busy
  );
  modport slave (
    input  i_in_vld, i_multa_ns, i_multb_ns, i_in_last, i_product, i_res_rdy,
    output o_in_rdy, o_res, o_res_ovf, o_res_vld, o_busy
  );
endinterface

// File: rtl/mac_accum_stage.sv
// mac_accum_stage: sums mult32x32 products over tagged operand sequences into a 2-entry result FIFO
//   i_clk  clock
//   i_rst  asynchronous active-high reset
//   bus    mac_accum_stage_if.slave (operand handshake, aligned product, result handshake, busy)
//   MULT_LAT  multiplier latency in cycles (>=1); ACC_W accumulator/result width (>=64)
//   Define MAC_ACC_SAT_EN to saturate on signed overflow instead of wrapping.
module mac_accum_stage #(
  parameter int MULT_LAT = 2,
  parameter int ACC_W    = 72
) (
  input logic              i_clk,
  input logic              i_rst,
  mac_accum_stage_if.slave bus
);
  localparam int PW = $clog2(MULT_LAT + 3) + 1;
  localparam int M  = ACC_W - 1;
  logic [MULT_LAT-1:0] vld_q, vld_d, sgn_q, sgn_d, last_q, last_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                ovf_q, ovf_d;
  logic [ACC_W:0]      mem_q [2];
  logic [ACC_W:0]      mem_d [2];
  logic                wr_q, wr_d, rd_q, rd_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [PW-1:0]       pend;
  logic                in_fire, al_vld, al_sgn, al_last, ovf_now, flag, push, pop;
  logic [ACC_W-1:0]    ext_s, ext_u, ext, sum, sum_f;
  // Credit covers results already queued plus sequence closers still in the multiplier.
  always_comb begin
    pend = PW'(cnt_q);
    for (int i = 0; i < MULT_LAT; i++) pend = pend + PW'(vld_q[i] & last_q[i]);
  end
  always_comb begin
    in_fire = bus.i_in_vld && bus.o_in_rdy;
    al_vld  = vld_q[MULT_LAT-1];
    al_sgn  = sgn_q[MULT_LAT-1];
    al_last = last_q[MULT_LAT-1];
    ext_s   = ACC_W'($signed(bus.i_product));
    ext_u   = ACC_W'(bus.i_product);
    ext     = al_sgn ? ext_s : ext_u;
    sum     = acc_q + ext;
    ovf_now = (acc_q[M] == ext[M]) && (sum[M] != acc_q[M]);
`ifdef MAC_ACC_SAT_EN
    sum_f   = ovf_now ? (ext[M] ? {1'b1, {M{1'b0}}} : {1'b0, {M{1'b1}}}) : sum;
`else
    sum_f   = sum;
`endif
    flag    = ovf_q | ovf_now;
    push    = al_vld && al_last;
    pop     = (cnt_q != 2'd0) && bus.i_res_rdy;
    vld_d   = MULT_LAT'({vld_q, in_fire});
    sgn_d   = MULT_LAT'({sgn_q, bus.i_multa_ns | bus.i_multb_ns});
    last_d  = MULT_LAT'({last_q, in_fire & bus.i_in_last});
    acc_d   = al_vld ? (al_last ? '0 : sum_f) : acc_q;
    ovf_d   = al_vld ? (!al_last && flag) : ovf_q;
    cnt_d   = cnt_q + 2'(push) - 2'(pop);
    wr_d    = wr_q ^ push;
    rd_d    = rd_q ^ pop;
    mem_d   = mem_q;
    if (push) mem_d[wr_q] = {sum_f, flag};
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      vld_q  <= '0;
      sgn_q  <= '0;
      last_q <= '0;
      acc_q  <= '0;
      ovf_q  <= 1'b0;
      mem_q  <= '{default: '0};
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      vld_q  <= vld_d;
      sgn_q  <= sgn_d;
      last_q <= last_d;
      acc_q  <= acc_d;
      ovf_q  <= ovf_d;
      mem_q  <= mem_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
    end
  always_ff @(posedge i_clk)
    if (!i_rst) assert (!(push && !pop && cnt_q == 2'd2));
  assign bus.o_in_rdy  = !i_rst && (pend < PW'(2));
  assign bus.o_res_vld = cnt_q != 2'd0;
  assign {bus.o_res, bus.o_res_ovf} = mem_q[rd_q];
  assign bus.o_busy    = (|vld_q) || (acc_q != '0) || ovf_q || (cnt_q != 2'd0);
endmodule

// File: tb/tb_mac_accum_stage.sv
// tb_mac_accum_stage: directed self-checking bench for mac_accum_stage
module tb_mac_accum_stage;
  localparam int L = 2;
  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  int          cyc   = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          last_acc = 0;
  int          n;
  logic [31:0] ain = '0;
  logic [31:0] bin = '0;
  logic [63:0] p0_in;
  logic [63:0] p1_in = '0;
  logic [63:0] d0 [L] = '{default: '0};
  logic [63:0] d1 [L] = '{default: '0};
  logic [71:0] q_res[$];
  logic        q_ovf[$];
  int          q_cyc[$];
  logic [63:0] exp4;
  mac_accum_stage_if #(.ACC_W(72)) b0 ();
  mac_accum_stage_if #(.ACC_W(64)) b1 ();
  mac_accum_stage #(.MULT_LAT(L), .ACC_W(72)) u0 (.i_clk(clk), .i_rst(rst), .bus(b0.slave));
  mac_accum_stage #(.MULT_LAT(L), .ACC_W(64)) u1 (.i_clk(clk), .i_rst(rst), .bus(b1.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [63:0] mul(input logic [31:0] a, input logic [31:0] b, input logic sa, input logic sb);
    logic signed [64:0] xa, xb, pr;
    xa = {{33{sa & a[31]}}, a};
    xb = {{33{sb & b[31]}}, b};
    pr = xa * xb;
    return pr[63:0];
  endfunction
  assign p0_in = mul(ain, bin, b0.i_multa_ns, b0.i_multb_ns);
  assign b0.i_product = d0[L-1];
  assign b1.i_product = d1[L-1];
  always @(posedge clk) begin
    d0[0] <= p0_in;
    d1[0] <= p1_in;
    for (int i = 1; i < L; i++) begin
      d0[i] <= d0[i-1];
      d1[i] <= d1[i-1];
    end
  end
  always @(negedge clk) begin
    #1;
    if (b0.o_res_vld && b0.i_res_rdy) begin
      q_res.push_back(b0.o_res);
      q_ovf.push_back(b0.o_res_ovf);
      q_cyc.push_back(cyc);
    end
  end
  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, input logic l);
    int k = 0;
    ain = a;
    bin = b;
    b0.i_multa_ns = s;
    b0.i_multb_ns = s;
    b0.i_in_last  = l;
    b0.i_in_vld   = 1'b1;
    while (!b0.o_in_rdy && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("issue_wait", k < 50, 1'b1);
    last_acc = cyc;
    @(negedge clk);
    b0.i_in_vld = 1'b0;
  endtask
  task automatic wait_res(input int want);
    int k = 0;
    while (q_res.size() < want && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("res_wait", q_res.size() >= want, 1'b1);
  endtask
  task automatic drain();
    repeat (3) @(negedge clk);
    q_res.delete();
    q_ovf.delete();
    q_cyc.delete();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    {b0.i_in_vld, b0.i_multa_ns, b0.i_multb_ns, b0.i_in_last, b0.i_res_rdy} = '0;
    {b1.i_in_vld, b1.i_multa_ns, b1.i_multb_ns, b1.i_in_last, b1.i_res_rdy} = '0;
    repeat (2) @(negedge clk);
    check("rst_res_vld", b0.o_res_vld, 1'b0);
    check("rst_in_rdy", b0.o_in_rdy, 1'b0);
    check("rst_busy", b0.o_busy, 1'b0);
    check("rst_res", b0.o_res, 72'd0);
    check("rst_ovf", b0.o_res_ovf, 1'b0);
    rst = 1'b0;
    b0.i_res_rdy = 1'b1;
    @(negedge clk);
    check("idle_rdy", b0.o_in_rdy, 1'b1);
    issue(32'd3, 32'd1, 1'b1, 1'b0);
    check("t1_busy", b0.o_busy, 1'b1);
    issue(32'hFFFF_FFFB, 32'd1, 1'b1, 1'b0);
    issue(32'd7, 32'd1, 1'b1, 1'b0);
    issue(32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1);
    wait_res(1);
    check("t1_res", q_res[0], 72'd4);
    check("t1_ovf", q_ovf[0], 1'b0);
    check("t1_lat", q_cyc[0] == last_acc + L + 1, 1'b1);
    drain();
    check("t1_idle", b0.o_busy, 1'b0);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
    wait_res(1);
    check("t2_res", q_res[0], 72'h00_FFFF_FFFE_0000_0001);
    check("t2_ovf", q_ovf[0], 1'b0);
    drain();
    b0.i_res_rdy = 1'b0;
    issue(32'd1, 32'd1, 1'b1, 1'b1);
    issue(32'd2, 32'd1, 1'b1, 1'b1);
    check("t3_rdy_low", b0.o_in_rdy, 1'b0);
    repeat (4) @(negedge clk);
    check("t3_vld_held", b0.o_res_vld, 1'b1);
    check("t3_rdy_full", b0.o_in_rdy, 1'b0);
    check("t3_no_pop", q_res.size(), 72'd0);
    b0.i_res_rdy = 1'b1;
    issue(32'd3, 32'd1, 1'b1, 1'b1);
    check("t3_acc_after_pop", last_acc > q_cyc[0], 1'b1);
    wait_res(3);
    for (int i = 0; i < 3; i++) check("t3_order", q_res[i], 72'(i + 1));
    drain();
    check("t4_rdy", b1.o_in_rdy, 1'b1);
    b1.i_multa_ns = 1'b1;
    b1.i_multb_ns = 1'b1;
    b1.i_in_last  = 1'b0;
    b1.i_in_vld   = 1'b1;
    p1_in = 64'h7FFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    b1.i_in_last = 1'b1;
    p1_in = 64'd1;
    @(negedge clk);
    b1.i_in_vld = 1'b0;
    n = 0;
    while (!b1.o_res_vld && n < 20) begin
      @(negedge clk);
      n++;
    end
`ifdef MAC_ACC_SAT_EN
    exp4 = 64'h7FFF_FFFF_FFFF_FFFF;
`else
    exp4 = 64'h8000_0000_0000_0000;
`endif
    check("t4_vld", b1.o_res_vld, 1'b1);
    check("t4_res", b1.o_res, exp4);
    check("t4_ovf", b1.o_res_ovf, 1'b1);
    b1.i_res_rdy = 1'b1;
    issue(32'd10, 32'd1, 1'b1, 1'b0);
    issue(32'd20, 32'd1, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    check("t5_rst_vld", b0.o_res_vld, 1'b0);
    check("t5_rst_rdy", b0.o_in_rdy, 1'b0);
    check("t5_rst_busy", b0.o_busy, 1'b0);
    check("t5_rst_res", b0.o_res, 72'd0);
    @(negedge clk);
    check("t5_rst_vld2", b0.o_res_vld, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    issue(32'd5, 32'd1, 1'b1, 1'b0);
    issue(32'd6, 32'd1, 1'b1, 1'b1);
    wait_res(1);
    check("t5_res", q_res[0], 72'd11);
    check("t5_ovf", q_ovf[0], 1'b0);
    drain();
    for (int k = 1; k <= 8; k++) issue(32'(k), 32'd1, 1'b1, 1'b1);
    wait_res(8);
    for (int i = 0; i < 8; i++) begin
      check("t6_val", q_res[i], 72'(i + 1));
      check("t6_ovf", q_ovf[i], 1'b0);
    end
    drain();
    check("t6_idle", b0.o_busy, 1'b0);
    check("t6_rdy", b0.o_in_rdy, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
